// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types for cache_mem_ctrl: FSM state encoding, latched request record
// and a word-alignment helper used for every memory address.
package cache_mem_ctrl_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_RD    = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Request fields are sized by DW_DEFAULT; override DATA_WIDTH and this together.
    typedef struct packed {
        logic                  read;
        logic                  dirty;
        logic [DW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] vaddr;
        logic [DW_DEFAULT-1:0] vdata;
    } req_t;

    function automatic logic [DW_DEFAULT-1:0] word_addr(input logic [DW_DEFAULT-1:0] a);
        return a & ~(DW_DEFAULT'(3));
    endfunction

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache-side request/response and memory-side strobes of cache_mem_ctrl,
// bundled in one interface; slave is the controller, master is its environment.
interface cache_mem_ctrl_if #(
    parameter int DW = 32
);
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqRead;
    logic          ReqDirty;
    logic [DW-1:0] ReqA;
    logic [DW-1:0] ReqVA;
    logic [DW-1:0] ReqVD;
    logic          RespValid;
    logic [DW-1:0] RespRD;
    logic [DW-1:0] MemA;
    logic [DW-1:0] MemWD;
    logic          MemWE;
    logic          MemRE;
    logic [DW-1:0] MemRD;

    modport slave (
        input  ReqValid, ReqRead, ReqDirty, ReqA, ReqVA, ReqVD, MemRD,
        output ReqReady, RespValid, RespRD, MemA, MemWD, MemWE, MemRE
    );

    modport master (
        output ReqValid, ReqRead, ReqDirty, ReqA, ReqVA, ReqVD, MemRD,
        input  ReqReady, RespValid, RespRD, MemA, MemWD, MemWE, MemRE
    );
endinterface

// File: rtl/cache_mem_ctrl_mem_lat_counter.sv
// Loadable down-counter timing the memory read latency; o_expire marks the
// cycle in which read data is valid, o_zero marks an idle counter.
module mem_lat_counter #(
    parameter int LATENCY = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_zero,
    output logic o_expire
);
    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(LATENCY);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero   = (r_count == '0);
    assign o_expire = (r_count == CW'(1));

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for cache misses: optional victim writeback plus optional
// refill read on a single-port memory. CACHE_MEM_WB_BUFFER_EN adds a one-entry writeback buffer.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DW_DEFAULT,
    parameter int MEM_LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    cache_mem_ctrl_if.slave io_bus
);

`ifdef CACHE_MEM_WB_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_next;
    req_t                  r_req;
    logic [DATA_WIDTH-1:0] r_resp_rd;
    logic [DATA_WIDTH-1:0] w_mem_a;
    logic [DATA_WIDTH-1:0] w_mem_wd;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_mem_we;
    logic                  w_mem_re;
    logic                  w_resp_valid;
    logic                  w_cnt_load;
    logic                  w_cnt_zero;
    logic                  w_cnt_expire;
    logic                  w_fwd_hit;
    logic                  w_buf_block;
    logic                  w_unused;

`ifdef CACHE_MEM_WB_BUFFER_EN
    logic                  r_buf_valid;
    logic [DATA_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_data;

    // Refill of the buffered word is served from the buffer without touching memory.
    assign w_fwd_hit   = r_buf_valid & io_bus.ReqRead & (word_addr(io_bus.ReqA) == r_buf_addr);
    assign w_buf_block = r_buf_valid & io_bus.ReqDirty;
    assign w_buf_data  = r_buf_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else if (w_accept && io_bus.ReqDirty) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= word_addr(io_bus.ReqVA);
            r_buf_data  <= io_bus.ReqVD;
        end else if (r_state == ST_DRAIN) begin
            r_buf_valid <= 1'b0;
        end
    end
`else
    assign w_fwd_hit   = 1'b0;
    assign w_buf_block = 1'b0;
    assign w_buf_data  = '0;
`endif

    assign w_accept = io_bus.ReqValid & w_ready;
    assign w_unused = r_req.dirty;

    mem_lat_counter #(
        .LATENCY (MEM_LATENCY)
    ) u_lat_counter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_cnt_load),
        .o_zero   (w_cnt_zero),
        .o_expire (w_cnt_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_a      = '0;
        w_mem_wd     = '0;
        w_resp_valid = 1'b0;
        w_cnt_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~w_buf_block;
                if (io_bus.ReqValid && w_ready) begin
                    if (io_bus.ReqDirty && !BUF_EN) begin
                        w_state_next = ST_WB;
                    end else if (w_fwd_hit) begin
                        w_state_next = ST_RESP;
                    end else if (io_bus.ReqRead) begin
                        w_state_next = ST_RD;
                    end else begin
                        w_state_next = ST_RESP;
                    end
                end
`ifdef CACHE_MEM_WB_BUFFER_EN
                else if (r_buf_valid) begin
                    w_state_next = ST_DRAIN;
                end
`endif
            end
            ST_WB: begin
                w_mem_we     = 1'b1;
                w_mem_a      = word_addr(r_req.vaddr);
                w_mem_wd     = r_req.vdata;
                w_state_next = r_req.read ? ST_RD : ST_RESP;
            end
            ST_RD: begin
                w_mem_a = word_addr(r_req.addr);
                // An idle counter inside RD can only mean the first RD cycle.
                if (w_cnt_zero) begin
                    w_mem_re   = 1'b1;
                    w_cnt_load = 1'b1;
                end
                if (w_cnt_expire) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                w_state_next = ST_IDLE;
            end
`ifdef CACHE_MEM_WB_BUFFER_EN
            ST_DRAIN: begin
                w_mem_we     = 1'b1;
                w_mem_a      = r_buf_addr;
                w_mem_wd     = r_buf_data;
                w_state_next = ST_IDLE;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_resp_rd <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_req <= '{read:  io_bus.ReqRead,
                           dirty: io_bus.ReqDirty,
                           addr:  io_bus.ReqA,
                           vaddr: io_bus.ReqVA,
                           vdata: io_bus.ReqVD};
                if (w_fwd_hit) begin
                    r_resp_rd <= w_buf_data;
                end else if (!io_bus.ReqRead) begin
                    r_resp_rd <= '0;
                end
            end else if (r_state == ST_RD && w_cnt_expire) begin
                r_resp_rd <= io_bus.MemRD;
            end
        end
    end

    // ReqReady must read 0 during reset even though IDLE is the reset state.
    assign io_bus.ReqReady  = w_ready & i_rst_n;
    assign io_bus.RespValid = w_resp_valid;
    assign io_bus.RespRD    = r_resp_rd;
    assign io_bus.MemA      = w_mem_a;
    assign io_bus.MemWD     = w_mem_wd;
    assign io_bus.MemWE     = w_mem_we;
    assign io_bus.MemRE     = w_mem_re;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: directed requests push expected responses and
// memory strobes into queues that a negedge monitor pops and compares.
module tb_cache_mem_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    resp_exp_t resp_q[$];
    mem_exp_t  mem_q[$];
    resp_exp_t mon_r;
    mem_exp_t  mon_m;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_mem_ctrl_if #(.DW(DW)) bus ();

    cache_mem_ctrl #(
        .DATA_WIDTH  (DW),
        .MEM_LATENCY (LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // Synchronous memory: write on the strobe edge, read data LAT cycles after MemRE.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | (32'(i) << 2);
            mem[64] <= 32'hDEAD_BEEF;
            for (int k = 0; k < LAT; k++) rd_pipe[k] <= 32'hEEEE_EEEE;
        end else begin
            if (bus.MemWE) mem[bus.MemA[11:2]] <= bus.MemWD;
            rd_pipe[0] <= bus.MemRE ? mem[bus.MemA[11:2]] : 32'hEEEE_EEEE;
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign bus.MemRD = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.RespValid) begin
                $display("resp cyc=%0d data=%h", cyc, bus.RespRD);
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(bus.RespValid), 32'h0);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_data", bus.RespRD, mon_r.data);
                    chk("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
                    chk("resp_ready_low", 32'(bus.ReqReady), 32'h0);
                end
            end
            if (bus.MemWE || bus.MemRE) begin
                $display("mem cyc=%0d we=%0b re=%0b a=%h wd=%h", cyc, bus.MemWE, bus.MemRE, bus.MemA, bus.MemWD);
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", {30'h0, bus.MemWE, bus.MemRE}, 32'h0);
                end else begin
                    mon_m = mem_q.pop_front();
                    chk("mem_we", 32'(bus.MemWE), 32'(mon_m.we));
                    chk("mem_re", 32'(bus.MemRE), 32'(!mon_m.we));
                    chk("mem_addr", bus.MemA, mon_m.addr);
                    if (mon_m.we) chk("mem_wdata", bus.MemWD, mon_m.wd);
                    if (mon_m.cyc >= 0) chk("mem_cycle", 32'(cyc), 32'(mon_m.cyc));
                end
            end
        end
    end

    // we_k / re_k: cycle of the write / read strobe after accept, -1 when absent.
    task automatic issue(input string tag, input logic rd, input logic dirty,
                         input logic [31:0] a, input logic [31:0] va, input logic [31:0] vd,
                         input logic [31:0] exp_data, input int resp_k, input int we_k,
                         input int re_k, input logic [31:0] re_addr, input int exp_stalls);
        int stalls;
        int acc0;
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqRead  = rd;
        bus.ReqDirty = dirty;
        bus.ReqA     = a;
        bus.ReqVA    = va;
        bus.ReqVD    = vd;
        #1;
        stalls = 0;
        while (!bus.ReqReady && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        if (!bus.ReqReady) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout actual=no_accept required=accept", tag);
            bus.ReqValid = 1'b0;
            return;
        end
        acc0 = cyc;
        if (we_k > 0) mem_q.push_back('{1'b1, va & 32'hFFFF_FFFC, vd, acc0 + we_k});
        if (re_k > 0) mem_q.push_back('{1'b0, re_addr, 32'h0, acc0 + re_k});
        resp_q.push_back('{exp_data, acc0 + resp_k});
        $display("req %s rd=%0b dirty=%0b a=%h va=%h vd=%h accept_cyc=%0d", tag, rd, dirty, a, va, vd, acc0);
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        bus.ReqRead  = 1'($urandom);
        bus.ReqDirty = 1'($urandom);
        bus.ReqA     = $urandom;
        bus.ReqVA    = $urandom;
        bus.ReqVD    = $urandom;
        for (int k = 1; k <= resp_k; k++) begin
            @(negedge clk);
            chk({tag, "_busy_ready"}, 32'(bus.ReqReady), 32'h0);
        end
    endtask

    task automatic reset_mid_rd();
        int acc0;
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqRead  = 1'b1;
        bus.ReqDirty = 1'b0;
        bus.ReqA     = 32'h100;
        #1;
        chk("rst_req_ready", 32'(bus.ReqReady), 32'h1);
        acc0 = cyc;
        mem_q.push_back('{1'b0, 32'h100, 32'h0, acc0 + 1});
        $display("req reset_abort rd=1 dirty=0 a=%h accept_cyc=%0d", bus.ReqA, acc0);
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_mema", bus.MemA, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ReqReady), 32'h0);
        chk("rst_respvalid", 32'(bus.RespValid), 32'h0);
        chk("rst_resprd", bus.RespRD, 32'h0);
        chk("rst_mema", bus.MemA, 32'h0);
        chk("rst_memwd", bus.MemWD, 32'h0);
        chk("rst_memwe", 32'(bus.MemWE), 32'h0);
        chk("rst_memre", 32'(bus.MemRE), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(bus.ReqReady), 32'h1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ReqValid = 1'b0;
        bus.ReqRead  = 1'b0;
        bus.ReqDirty = 1'b0;
        bus.ReqA     = '0;
        bus.ReqVA    = '0;
        bus.ReqVD    = '0;
        repeat (2) @(negedge clk);
        chk("init_ready", 32'(bus.ReqReady), 32'h0);
        chk("init_respvalid", 32'(bus.RespValid), 32'h0);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_release_ready", 32'(bus.ReqReady), 32'h1);

        issue("clean", 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 4, -1, 1, 32'h100, 0);
        reset_mid_rd();
`ifndef CACHE_MEM_WB_BUFFER_EN
        issue("dirty", 1'b1, 1'b1, 32'h104, 32'h200, 32'h1234_5678, 32'hA000_0104, 5, 1, 2, 32'h104, 0);
        issue("wronly", 1'b0, 1'b1, 32'h400, 32'h208, 32'h55AA_55AA, 32'h0, 2, 1, -1, 32'h0, 0);
        issue("rd_wb", 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h1234_5678, 4, -1, 1, 32'h200, 0);
        issue("unalign", 1'b1, 1'b0, 32'h20B, 32'h0, 32'h0, 32'h55AA_55AA, 4, -1, 1, 32'h208, 0);
        issue("noop", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, -1, -1, 32'h0, 0);
        issue("wr_then_rd", 1'b1, 1'b1, 32'h30C, 32'h30E, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 5, 1, 2, 32'h30C, 0);
`else
        issue("buf_dirty", 1'b1, 1'b1, 32'h104, 32'h200, 32'hCAFE_F00D, 32'hA000_0104, 4, -1, 1, 32'h104, 0);
        issue("buf_fwd", 1'b1, 1'b0, 32'h202, 32'h0, 32'h0, 32'hCAFE_F00D, 1, -1, -1, 32'h0, 0);
        mem_q.push_back('{1'b1, 32'h200, 32'hCAFE_F00D, -1});
        issue("buf_stall", 1'b1, 1'b1, 32'h108, 32'h300, 32'h1111_1111, 32'hA000_0108, 4, -1, 1, 32'h108, 2);
        issue("buf_rd_drained", 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 32'hCAFE_F00D, 4, -1, 1, 32'h200, 0);
        issue("buf_fwd2", 1'b1, 1'b0, 32'h301, 32'h0, 32'h0, 32'h1111_1111, 1, -1, -1, 32'h0, 0);
        mem_q.push_back('{1'b1, 32'h300, 32'h1111_1111, -1});
        issue("buf_wronly", 1'b0, 1'b1, 32'h0, 32'h404, 32'h7777_7777, 32'h0, 1, -1, -1, 32'h0, 2);
        mem_q.push_back('{1'b1, 32'h404, 32'h7777_7777, -1});
        repeat (4) @(negedge clk);
        issue("buf_rd_404", 1'b1, 1'b0, 32'h404, 32'h0, 32'h0, 32'h7777_7777, 4, -1, 1, 32'h404, 0);
`endif
        repeat (12) @(negedge clk);
        chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Memory-side responder for the data cache's miss/eviction interface. It accepts one request per miss from the cache: an optional dirty-victim writeback plus an optional refill read. It sequences both onto a single-port synchronous data memory with fixed read latency, and returns refill data to the cache with a one-cycle response pulse. It sits between the cache and data memory, and is the consumer of the cache's victim address, victim data and victim write-enable outputs.

## Interface
- DATA_WIDTH, 32, data and address width
- MEM_LATENCY, 2, cycles from MemRE to valid MemRD (≥1)
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  request accepted on the edge where ReqValid&ReqReady
- ReqRead  in  1  refill read required
- ReqDirty  in  1  victim writeback required
- ReqA  in  DATA_WIDTH  refill address
- ReqVA  in  DATA_WIDTH  victim address
- ReqVD  in  DATA_WIDTH  victim data
- RespValid  out  1  one-cycle completion pulse
- RespRD  out  DATA_WIDTH  refill data, valid with RespValid
- MemA  out  DATA_WIDTH  memory word address, bits [1:0] forced 0
- MemWD  out  DATA_WIDTH  memory write data
- MemWE  out  1  memory write strobe, one cycle per write
- MemRE  out  1  memory read strobe, one cycle per read
- MemRD  in  DATA_WIDTH  memory read data

## Operation
- Reset is asynchronous and active-low. All outputs are 0 while RST_N is low: ReqReady=0, RespValid=0, RespRD=0, MemA=0, MemWD=0, MemWE=0, MemRE=0. FSM goes to IDLE, the latency counter clears and the buffer is invalidated.
- Reset mid-operation aborts the transfer. An in-flight or buffered writeback is discarded; no response is issued.
- Request fields are sampled only at acceptance. Later input changes are ignored.
- FSM states:
  - IDLE: ReqReady=1.
    - On accept with ReqDirty=1 → WB.
    - On accept with ReqDirty=0 and ReqRead=1 → RD.
    - On accept with both 0 → RESP.
    - With ReqValid=0 → IDLE.
  - WB: MemWE=1, MemA=victim address, MemWD=victim data. Next state → RD if ReqRead, else RESP.
  - RD: MemRE=1 for its first cycle only; the counter loads MEM_LATENCY. Captures MemRD into RespRD when the counter expires, then → RESP.
  - RESP: RespValid=1 for exactly one cycle; RespRD holds the refill data, or 0 for a write-only request. Next state → IDLE.
- ReqReady is low in all states except IDLE; there is no request queue.
- RespRD holds its value until the next capture.

## Timing
- Accept edge = cycle 0.
- Clean refill: MemRE in cycle 1, MemRD valid in cycle 1+MEM_LATENCY, RespValid in cycle 2+MEM_LATENCY (cycle 4 at default).
- Dirty refill: MemWE in cycle 1, MemRE in cycle 2, RespValid in cycle 3+MEM_LATENCY.
- Write-only: MemWE in cycle 1, RespValid in cycle 2.
- Earliest next accept: the cycle after RespValid.

## Configuration
- CACHE_MEM_WB_BUFFER_EN defined: one-entry writeback buffer.
  - A dirty victim is captured into the buffer at accept, and the read is issued first. Clean timing therefore applies to dirty refills.
  - A DRAIN state (MemWE=1 from the buffer) is entered from IDLE when the buffer is valid and no request is accepted in that cycle.
  - A new request with ReqDirty=1 while the buffer is valid holds ReqReady=0 until the drain completes. Clean requests are still accepted.
  - A refill whose ReqA word matches the buffered address skips memory: RespRD=buffer data, RespValid in cycle 1, and the buffer stays valid.
  - If a request arrives in the same cycle the FSM would enter DRAIN, the request wins and the drain waits.
- CACHE_MEM_WB_BUFFER_EN undefined: no buffer, no DRAIN state, and the FSM sequence above applies exactly.

## Structure
- The shared package holds the FSM state enum (IDLE, WB, RD, RESP, DRAIN) and a request struct (read, dirty, addr, vaddr, vdata).
- One sub-module, mem_lat_counter, implements the loadable down-counter with an expire flag.
- The buffer and forwarding compare are inline, inside the `ifdef.

## Test plan
- Reset values: drive RST_N low mid-RD with MEM_LATENCY=2 → all outputs 0 immediately; after release, ReqReady=1 and no RespValid is ever issued.
- Clean miss: ReqA=0x100, memory word 0x100 holds 0xDEADBEEF → MemRE in cycle 1 with MemA=0x100, RespValid in cycle 4 with RespRD=0xDEADBEEF, ReqReady low in cycles 1–4.
- Dirty miss, buffer disabled: ReqVA=0x200, ReqVD=0x12345678, ReqA=0x104 → MemWE in cycle 1 writing 0x12345678 to 0x200, MemRE in cycle 2, RespValid in cycle 5.
- Write-only: ReqRead=0, ReqDirty=1 → one MemWE, RespValid in cycle 2 with RespRD=0, and MemRE never asserted.
- Buffer enabled, dirty then forward:
  - First request, victim 0x200/0xCAFEF00D, refill 0x104 → RespValid in cycle 4.
  - Immediate second request with ReqA=0x202 → RespValid one cycle after its accept, with RespRD=0xCAFEF00D and no MemRE.
- Buffer enabled, back-to-back dirty requests → the second request is stalled (ReqReady=0) until the DRAIN MemWE cycle, then accepted.
